// File: rtl/server_multi_user_fsm.sv
// Round-robin user arbiter with frame authentication and OPU dispatch.
// One transaction in flight; all outputs registered.
module server_multi_user_fsm #(
  parameter int NUM_USERS = 4,
  parameter int DATA_W = 8,
  parameter int NUM_OPS = 4,
  parameter int KEY_W = 3,
  parameter logic [KEY_W-1:0] AUTH_KEY = 3'b101,
  parameter int TIMEOUT = 255,
  localparam int FRAME_W = 1 + KEY_W + NUM_OPS + DATA_W,
  localparam int OP_W = $clog2(NUM_OPS),
  localparam int U_W = $clog2(NUM_USERS),
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_USERS-1:0]         user_start,
  input  logic [NUM_USERS*FRAME_W-1:0] user_frame,
  output logic [NUM_USERS-1:0]         auth_done,
  output logic [NUM_USERS-1:0]         auth_fail,
  output logic [NUM_USERS-1:0]         user_done,
  output logic [NUM_USERS-1:0]         user_timeout,
  output logic                         busy,
  output logic [U_W-1:0]               op_user,
  output logic [OP_W-1:0]              op_code,
  output logic [DATA_W-1:0]            op_data,
  output logic                         op_start,
  input  logic                         op_done
);

  typedef enum logic [1:0] {IDLE, AUTH, OP, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic [U_W-1:0]       rr_ptr;
  logic [U_W-1:0]       gnt;
  logic                 gnt_vld;
  logic [FRAME_W-1:0]   frame_sel;
  logic [OP_W-1:0]      code_sel;
  logic                 flag_q;
  logic [KEY_W-1:0]     key_q;
  logic [NUM_OPS-1:0]   ops_q;
  logic [CNT_W-1:0]     cnt;
  logic                 pass;
  logic                 tmo;
  logic [NUM_USERS-1:0] user_oh;
  logic [3:0]           pulse_nx;

  function automatic logic [U_W-1:0] wrap_add(
    input logic [U_W-1:0] a,
    input int             b
  );
    return U_W'((int'(a) + b) % NUM_USERS);
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (!gnt_vld && user_start[wrap_add(rr_ptr, i)]) begin
        gnt_vld = 1'b1;
        gnt = wrap_add(rr_ptr, i);
      end
    end
  end

  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (gnt == U_W'(i)) frame_sel = user_frame[i*FRAME_W +: FRAME_W];
    end
  end

  always_comb begin
    code_sel = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (frame_sel[DATA_W+i]) code_sel = OP_W'(i);
    end
  end

  assign pass = !flag_q && (key_q == AUTH_KEY) && $onehot(ops_q);
  assign tmo = (cnt == CNT_W'(TIMEOUT - 1));
  assign user_oh = NUM_USERS'(1) << op_user;

  // pulse_nx: {auth_done, auth_fail, user_done, user_timeout}
  always_comb begin
    state_nx = state;
    pulse_nx = '0;
    unique case (state)
      IDLE: if (gnt_vld) state_nx = AUTH;
      AUTH: begin
        if (pass) begin
          state_nx = OP;
          pulse_nx[3] = 1'b1;
        end else begin
          state_nx = IDLE;
          pulse_nx[2] = 1'b1;
        end
      end
      OP: begin
        if (op_done) begin
          state_nx = DONE;
          pulse_nx[1] = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
          pulse_nx[0] = 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      flag_q <= 1'b0;
      key_q <= '0;
      ops_q <= '0;
      op_user <= '0;
      op_code <= '0;
      op_data <= '0;
      busy <= 1'b0;
      op_start <= 1'b0;
      auth_done <= '0;
      auth_fail <= '0;
      user_done <= '0;
      user_timeout <= '0;
    end else begin
      state <= state_nx;
      busy <= (state_nx != IDLE);
      op_start <= (state_nx == OP);
      auth_done <= pulse_nx[3] ? user_oh : '0;
      auth_fail <= pulse_nx[2] ? user_oh : '0;
      user_done <= pulse_nx[1] ? user_oh : '0;
      user_timeout <= pulse_nx[0] ? user_oh : '0;
      cnt <= (state == OP) ? cnt + 1'b1 : '0;
      if (state == IDLE && gnt_vld) begin
        op_user <= gnt;
        rr_ptr <= wrap_add(gnt, 1);
        {flag_q, key_q, ops_q} <= frame_sel[FRAME_W-1:DATA_W];
        op_code <= code_sel;
        op_data <= frame_sel[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_server_multi_user_fsm.sv
// Bench for server_multi_user_fsm: directed table, hand-written
// reset sequence and randomized transactions against a reference model.
module tb_server_multi_user_fsm;

  localparam int NU = 4;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  user_start = '0;
  logic [63:0] user_frame = '0;
  logic        op_done = 1'b0;
  logic [3:0]  auth_done, auth_fail, user_done, user_timeout;
  logic        busy, op_start;
  logic [1:0]  op_user, op_code;
  logic [7:0]  op_data;

  int total = 0;
  int bad = 0;
  int rr = 0;

  always #5 clk = ~clk;

  server_multi_user_fsm #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .user_start(user_start),
    .user_frame(user_frame),
    .auth_done(auth_done),
    .auth_fail(auth_fail),
    .user_done(user_done),
    .user_timeout(user_timeout),
    .busy(busy),
    .op_user(op_user),
    .op_code(op_code),
    .op_data(op_data),
    .op_start(op_start),
    .op_done(op_done)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] frames;
    int          delay;
    int          g;
    bit          pass;
    int          code;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic [3:0] m, input logic [63:0] f,
                              input int d, input int g, input bit p,
                              input int c, input logic [7:0] dt);
    vec_t v;
    v.mask = m;
    v.frames = f;
    v.delay = d;
    v.g = g;
    v.pass = p;
    v.code = c;
    v.data = dt;
    return v;
  endfunction

  function automatic logic [17:0] stat_now();
    return {busy, op_start, auth_done, auth_fail, user_done, user_timeout};
  endfunction

  // kind: 0 none, 1 auth_done, 2 auth_fail, 3 user_done, 4 user_timeout
  function automatic logic [17:0] exp_stat(input bit b, input bit s,
                                           input int kind, input int g);
    logic [3:0]  oh;
    logic [15:0] p;
    oh = 4'b0001 << g;
    p = '0;
    case (kind)
      1: p[15:12] = oh;
      2: p[11:8] = oh;
      3: p[7:4] = oh;
      4: p[3:0] = oh;
      default: p = '0;
    endcase
    return {b, s, p};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] m);
    for (int i = 0; i < NU; i++) begin
      if (m[(rr + i) % NU]) return (rr + i) % NU;
    end
    return 0;
  endfunction

  function automatic bit model_pass(input logic [15:0] fr);
    return fr[15] == 1'b0 && fr[14:12] == 3'b101 && $countones(fr[11:8]) == 1;
  endfunction

  function automatic int model_code(input logic [15:0] fr);
    for (int i = 0; i < 4; i++) begin
      if (fr[8+i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [15:0] rnd_frame();
    logic [3:0] oh;
    oh = 4'b0001 << $urandom_range(0, 3);
    if ($urandom_range(0, 3) != 0) return {1'b0, 3'b101, oh, 8'($urandom)};
    return 16'($urandom);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_txn(input logic [3:0] mask, input logic [63:0] frames,
                         input int delay, input int g, input bit pass,
                         input int code, input logic [7:0] data);
    logic [1:0] gb, cb;
    gb = g[1:0];
    cb = code[1:0];
    user_start = mask;
    user_frame = frames;
    op_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("auth_stat", 32'(stat_now()), 32'(exp_stat(1, 0, 0, g)));
    chk("grant", 32'(op_user), 32'(gb));
    user_start = 4'($urandom);
    user_frame = {$urandom, $urandom};
    op_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (!pass) begin
      chk("fail_stat", 32'(stat_now()), 32'(exp_stat(0, 0, 2, g)));
    end else begin
      chk("pass_stat", 32'(stat_now()), 32'(exp_stat(1, 1, 1, g)));
      chk("op_fields", 32'({op_user, op_code, op_data}), 32'({gb, cb, data}));
      for (int k = 0; k < TO; k++) begin
        op_done = (k == delay);
        user_start = 4'($urandom);
        user_frame = {$urandom, $urandom};
        @(negedge clk);
        if (k == delay) begin
          chk("done_stat", 32'(stat_now()), 32'(exp_stat(1, 0, 3, g)));
          op_done = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("post_done", 32'(stat_now()), 32'(exp_stat(0, 0, 0, g)));
          break;
        end else if (k == TO - 1) begin
          chk("timeout_stat", 32'(stat_now()), 32'(exp_stat(0, 0, 4, g)));
        end else begin
          chk("op_hold", 32'(stat_now()), 32'(exp_stat(1, 1, 0, g)));
          chk("op_stable", 32'({op_user, op_code, op_data}),
              32'({gb, cb, data}));
        end
      end
    end
    rr = (g + 1) % NU;
    user_start = '0;
    op_done = 1'b0;
  endtask

  localparam logic [63:0] ALL4 = {16'h5813, 16'h5412, 16'h5211, 16'h5110};

  initial begin
    logic [3:0]  m;
    logic [63:0] fr;
    logic [15:0] f1;
    int          g;

    tbl[0]  = mk(4'hF, ALL4, 2, 0, 1, 0, 8'h10);
    tbl[1]  = mk(4'hF, ALL4, 0, 1, 1, 1, 8'h11);
    tbl[2]  = mk(4'hF, ALL4, TO - 1, 2, 1, 2, 8'h12);
    tbl[3]  = mk(4'hF, ALL4, 1, 3, 1, 3, 8'h13);
    tbl[4]  = mk(4'b0101, ALL4, 3, 0, 1, 0, 8'h10);
    tbl[5]  = mk(4'b0010, {32'h0, 16'h543C, 16'h0}, 3, 1, 1, 2, 8'h3C);
    tbl[6]  = mk(4'b0001, {48'h0, 16'hD43C}, 0, 0, 0, 0, 8'h3C);
    tbl[7]  = mk(4'b0001, {48'h0, 16'h563C}, 0, 0, 0, 0, 8'h3C);
    tbl[8]  = mk(4'b0001, {48'h0, 16'h343C}, 0, 0, 0, 0, 8'h3C);
    tbl[9]  = mk(4'b0100, {16'h0, 16'h5422, 32'h0}, -1, 2, 1, 2, 8'h22);
    tbl[10] = mk(4'b1010, ALL4, 0, 3, 1, 3, 8'h13);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'({stat_now(), op_user, op_code, op_data}), 32'h0);
    rst_n = 1'b1;
    rr = 0;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].mask, tbl[i].frames, tbl[i].delay, tbl[i].g,
              tbl[i].pass, tbl[i].code, tbl[i].data);
    end

    // Reset on the second OP cycle drops the grant with no user_done.
    user_start = 4'b1000;
    user_frame = {16'h5855, 48'h0};
    @(negedge clk);
    user_start = '0;
    @(negedge clk);
    chk("mid_op0", 32'(op_start), 32'h1);
    @(negedge clk);
    chk("mid_op1", 32'(op_start), 32'h1);
    rst_n = 1'b0;
    op_done = 1'b1;
    @(negedge clk);
    chk("mid_rst", 32'({stat_now(), op_user, op_code, op_data}), 32'h0);
    rst_n = 1'b1;
    op_done = 1'b0;
    rr = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst", 32'(stat_now()), 32'h0);
    end
    run_txn(4'b0110, ALL4, 2, 1, 1, 1, 8'h11);

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        user_start = '0;
        op_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle", 32'(stat_now()), 32'h0);
      end
      op_done = 1'b0;
      m = 4'($urandom_range(1, 15));
      for (int u = 0; u < NU; u++) fr[u*16 +: 16] = rnd_frame();
      g = model_grant(m);
      f1 = fr[g*16 +: 16];
      run_txn(m, fr, $urandom_range(0, 6), g, model_pass(f1),
              model_code(f1), f1[7:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
